// File: rtl/bp_be_pkg.sv
// Shared types for the BE long-latency divide pipe: operation encoding,
// control FSM states and small op-decode helpers.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_div_op_div  = 2'b00,
    e_div_op_divu = 2'b01,
    e_div_op_rem  = 2'b10,
    e_div_op_remu = 2'b11
  } bp_be_div_op_e;

  typedef enum logic [1:0] {
    e_div_idle = 2'b00,
    e_div_calc = 2'b01,
    e_div_done = 2'b10
  } bp_be_div_state_e;

  function automatic logic div_op_signed(input bp_be_div_op_e op);
    return (op == e_div_op_div) || (op == e_div_op_rem);
  endfunction

  function automatic logic div_op_rem(input bp_be_div_op_e op);
    return (op == e_div_op_rem) || (op == e_div_op_remu);
  endfunction

endpackage

// File: rtl/bp_be_div_iter_step.sv
// One combinational restoring-division step retiring bits_per_iter_p quotient
// bits: shift the next dividend bits into the partial remainder and subtract.
module bp_be_div_iter_step
  import bp_be_pkg::*;
#(
  parameter int width_p         = 64,
  parameter int bits_per_iter_p = 1
) (
  input  logic [width_p-1:0]         rem_i,
  input  logic [bits_per_iter_p-1:0] dividend_bits_i,
  input  logic [width_p-1:0]         divisor_i,
  output logic [width_p-1:0]         rem_o,
  output logic [bits_per_iter_p-1:0] quot_o
);

  // Two guard bits hold 4*rem + bits and 3*divisor without overflow.
  localparam int ext_lp = width_p + 2;

  logic [ext_lp-1:0] shifted;
  logic [ext_lp-1:0] d1;

  // Shifted partial remainder and zero-extended divisor
  always_comb begin
    shifted = ({2'b00, rem_i} << bits_per_iter_p)
            | {{(ext_lp-bits_per_iter_p){1'b0}}, dividend_bits_i};
    d1      = {2'b00, divisor_i};
  end

  if (bits_per_iter_p == 1) begin : g_radix2
    // Single compare-and-subtract
    always_comb begin
      if (shifted >= d1) begin
        rem_o  = shifted[width_p-1:0] - d1[width_p-1:0];
        quot_o = 1'b1;
      end else begin
        rem_o  = shifted[width_p-1:0];
        quot_o = 1'b0;
      end
    end
  end else begin : g_radix4
    logic [ext_lp-1:0] d2;
    logic [ext_lp-1:0] d3;

    // Divisor multiples for the radix-4 digit select
    always_comb begin
      d2 = d1 << 1;
      d3 = d1 + d2;
    end

    // Largest multiple not exceeding the shifted remainder picks the digit
    always_comb begin
      if (shifted >= d3) begin
        rem_o  = shifted[width_p-1:0] - d3[width_p-1:0];
        quot_o = 2'b11;
      end else if (shifted >= d2) begin
        rem_o  = shifted[width_p-1:0] - d2[width_p-1:0];
        quot_o = 2'b10;
      end else if (shifted >= d1) begin
        rem_o  = shifted[width_p-1:0] - d1[width_p-1:0];
        quot_o = 2'b01;
      end else begin
        rem_o  = shifted[width_p-1:0];
        quot_o = 2'b00;
      end
    end
  end

endmodule

// File: rtl/bp_be_pipe_long_div.sv
// Iterative RV64 DIV/DIVU/REM/REMU (and W forms) pipe with early-out,
// flush abort and a valid/yumi result handshake.
module bp_be_pipe_long_div
  import bp_be_pkg::*;
#(
  parameter int width_p          = 64,
  parameter int word_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int bits_per_iter_p  = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        v_i,
  output logic                        ready_o,
  input  bp_be_div_op_e               op_i,
  input  logic                        opw_i,
  input  logic [reg_addr_width_p-1:0] rd_addr_i,
  input  logic [width_p-1:0]          rs1_i,
  input  logic [width_p-1:0]          rs2_i,
  input  logic                        flush_i,
  output logic                        v_o,
  input  logic                        yumi_i,
  output logic [reg_addr_width_p-1:0] rd_addr_o,
  output logic [width_p-1:0]          rd_data_o
);

  localparam int iters_lp     = width_p / bits_per_iter_p;
  localparam int iters_w_lp   = word_width_p / bits_per_iter_p;
  localparam int cnt_width_lp = $clog2(iters_lp + 1);
  localparam int ext_w_lp     = width_p - word_width_p;

  function automatic logic [width_p-1:0] pack_result(
    input logic               is_rem,
    input logic               is_w,
    input logic [width_p-1:0] quo,
    input logic [width_p-1:0] rem
  );
    logic [width_p-1:0] sel;
    sel = is_rem ? rem : quo;
    if (is_w) return {{ext_w_lp{sel[word_width_p-1]}}, sel[word_width_p-1:0]};
    else      return sel;
  endfunction

  bp_be_div_state_e state_r, state_n;

  bp_be_div_op_e                 op_r;
  logic                          opw_r;
  logic [reg_addr_width_p-1:0]   rd_addr_r;
  logic [width_p-1:0]            rem_r;
  logic [width_p-1:0]            quo_r;
  logic [width_p-1:0]            div_r;
  logic                          sign_q_r;
  logic                          sign_r_r;
  logic [cnt_width_lp-1:0]       cnt_r;
  logic [width_p-1:0]            rd_data_r;

  logic                          accept;
  logic                          last_iter;

  logic                          op_signed;
  logic [width_p-1:0]            a_ext, b_ext, min_neg;
  logic                          sign_a, sign_b;
  logic [width_p-1:0]            mag_a, mag_b;
  logic                          div_zero, div_ovf, early;
  logic [width_p-1:0]            q_early, r_early, early_data;
  logic [cnt_width_lp-1:0]       iter_cnt;

  logic [width_p-1:0]            step_rem;
  logic [bits_per_iter_p-1:0]    step_quot;
  logic [width_p-1:0]            quo_next, quo_fix, rem_fix, final_data;

  // Operand conditioning: extend W forms, take magnitudes, detect early-outs
  always_comb begin
    op_signed = div_op_signed(op_i);
    if (opw_i) begin
      a_ext    = {{ext_w_lp{op_signed & rs1_i[word_width_p-1]}}, rs1_i[word_width_p-1:0]};
      b_ext    = {{ext_w_lp{op_signed & rs2_i[word_width_p-1]}}, rs2_i[word_width_p-1:0]};
      min_neg  = {{(ext_w_lp+1){1'b1}}, {(word_width_p-1){1'b0}}};
      iter_cnt = cnt_width_lp'(iters_w_lp);
    end else begin
      a_ext    = rs1_i;
      b_ext    = rs2_i;
      min_neg  = {1'b1, {(width_p-1){1'b0}}};
      iter_cnt = cnt_width_lp'(iters_lp);
    end
    sign_a   = op_signed & a_ext[width_p-1];
    sign_b   = op_signed & b_ext[width_p-1];
    mag_a    = sign_a ? -a_ext : a_ext;
    mag_b    = sign_b ? -b_ext : b_ext;
    div_zero = (b_ext == {width_p{1'b0}});
    div_ovf  = op_signed & (a_ext == min_neg) & (b_ext == {width_p{1'b1}});
    early    = div_zero | div_ovf | (mag_a < mag_b);
    if (div_zero) begin
      q_early = {width_p{1'b1}};
      r_early = a_ext;
    end else if (div_ovf) begin
      q_early = a_ext;
      r_early = {width_p{1'b0}};
    end else begin
      q_early = {width_p{1'b0}};
      r_early = a_ext;
    end
    early_data = pack_result(div_op_rem(op_i), opw_i, q_early, r_early);
  end

  bp_be_div_iter_step #(
    .width_p         (width_p),
    .bits_per_iter_p (bits_per_iter_p)
  ) u_step (
    .rem_i           (rem_r),
    .dividend_bits_i (quo_r[width_p-1 -: bits_per_iter_p]),
    .divisor_i       (div_r),
    .rem_o           (step_rem),
    .quot_o          (step_quot)
  );

  // Sign fixup of the final iteration's quotient/remainder
  always_comb begin
    quo_next   = {quo_r[width_p-bits_per_iter_p-1:0], step_quot};
    quo_fix    = sign_q_r ? -quo_next : quo_next;
    rem_fix    = sign_r_r ? -step_rem : step_rem;
    final_data = pack_result(div_op_rem(op_r), opw_r, quo_fix, rem_fix);
  end

  // Control FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_div_idle;
    else         state_r <= state_n;
  end

  // Next-state logic; flush wins over both accept and yumi
  always_comb begin
    state_n   = state_r;
    accept    = 1'b0;
    last_iter = 1'b0;
    if (flush_i) begin
      state_n = e_div_idle;
    end else begin
      case (state_r)
        e_div_idle: begin
          if (v_i) begin
            accept  = 1'b1;
            state_n = early ? e_div_done : e_div_calc;
          end else begin
            state_n = e_div_idle;
          end
        end
        e_div_calc: begin
          last_iter = (cnt_r == cnt_width_lp'(1));
          state_n   = last_iter ? e_div_done : e_div_calc;
        end
        e_div_done: begin
          state_n = yumi_i ? e_div_idle : e_div_done;
        end
        default: state_n = e_div_idle;
      endcase
    end
  end

  // Datapath: latch request on accept, iterate in CALC, capture result
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_r      <= e_div_op_div;
      opw_r     <= 1'b0;
      rd_addr_r <= {reg_addr_width_p{1'b0}};
      rem_r     <= {width_p{1'b0}};
      quo_r     <= {width_p{1'b0}};
      div_r     <= {width_p{1'b0}};
      sign_q_r  <= 1'b0;
      sign_r_r  <= 1'b0;
      cnt_r     <= {cnt_width_lp{1'b0}};
      rd_data_r <= {width_p{1'b0}};
    end else if (flush_i) begin
      cnt_r <= {cnt_width_lp{1'b0}};
    end else if (accept) begin
      op_r      <= op_i;
      opw_r     <= opw_i;
      rd_addr_r <= rd_addr_i;
      rem_r     <= {width_p{1'b0}};
      quo_r     <= opw_i ? (mag_a << word_width_p) : mag_a;
      div_r     <= mag_b;
      sign_q_r  <= sign_a ^ sign_b;
      sign_r_r  <= sign_a;
      cnt_r     <= early ? {cnt_width_lp{1'b0}} : iter_cnt;
      if (early) rd_data_r <= early_data;
    end else if (state_r == e_div_calc) begin
      rem_r <= step_rem;
      quo_r <= quo_next;
      cnt_r <= cnt_r - cnt_width_lp'(1);
      if (last_iter) rd_data_r <= final_data;
    end
  end

  assign ready_o   = (state_r == e_div_idle);
  assign v_o       = (state_r == e_div_done);
  assign rd_addr_o = rd_addr_r;
  assign rd_data_o = rd_data_r;

endmodule

// File: tb/tb_bp_be_pipe_long_div.sv
// Directed bench for bp_be_pipe_long_div: radix-2 and radix-4 instances share
// stimulus; results, latencies, handshake, flush and reset are checked.
module tb_bp_be_pipe_long_div;
  import bp_be_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          v_i = 1'b0;
  logic          opw = 1'b0;
  logic          flush = 1'b0;
  logic          yumi = 1'b0;
  bp_be_div_op_e op = e_div_op_div;
  logic [4:0]    rd_addr = 5'd0;
  logic [63:0]   rs1 = 64'd0;
  logic [63:0]   rs2 = 64'd0;

  logic          ready1, v1, ready4, v4;
  logic [4:0]    addr1, addr4;
  logic [63:0]   data1, data4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bp_be_pipe_long_div #(.bits_per_iter_p(1)) dut (
    .clk_i(clk), .reset_i(reset), .v_i(v_i), .ready_o(ready1), .op_i(op), .opw_i(opw),
    .rd_addr_i(rd_addr), .rs1_i(rs1), .rs2_i(rs2), .flush_i(flush), .v_o(v1),
    .yumi_i(yumi), .rd_addr_o(addr1), .rd_data_o(data1));

  bp_be_pipe_long_div #(.bits_per_iter_p(2)) dut4 (
    .clk_i(clk), .reset_i(reset), .v_i(v_i), .ready_o(ready4), .op_i(op), .opw_i(opw),
    .rd_addr_i(rd_addr), .rs1_i(rs1), .rs2_i(rs2), .flush_i(flush), .v_o(v4),
    .yumi_i(yumi), .rd_addr_o(addr4), .rd_data_o(data4));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic take(input string tag);
    check({tag, "_yumi_legal"}, {63'd0, v1 & v4}, 64'd1);
    if (v1 && v4) begin
      yumi = 1'b1;
      step();
      yumi = 1'b0;
      check({tag, "_ready_after"}, {62'd0, ready1, ready4}, 64'd3);
    end else begin
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
    end
  endtask

  task automatic launch(input bp_be_div_op_e o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] ad);
    check("launch_ready", {62'd0, ready1, ready4}, 64'd3);
    op = o; opw = w; rs1 = a; rs2 = b; rd_addr = ad; v_i = 1'b1;
    step();
    v_i = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int e1, input int e4,
                             input logic [63:0] exp, input logic [4:0] ad);
    int lat1, lat4;
    logic [63:0] d1, d4;
    logic [4:0]  a1, a4;
    lat1 = 0; lat4 = 0; d1 = 64'd0; d4 = 64'd0; a1 = 5'd0; a4 = 5'd0;
    for (int c = 1; c <= 100; c++) begin
      if (v1 && lat1 == 0) begin lat1 = c; d1 = data1; a1 = addr1; end
      if (v4 && lat4 == 0) begin lat4 = c; d4 = data4; a4 = addr4; end
      if (lat1 != 0 && lat4 != 0) break;
      step();
    end
    check({tag, "_lat_r2"},  64'(lat1), 64'(e1));
    check({tag, "_lat_r4"},  64'(lat4), 64'(e4));
    check({tag, "_data_r2"}, d1, exp);
    check({tag, "_data_r4"}, d4, exp);
    check({tag, "_addr_r2"}, {59'd0, a1}, {59'd0, ad});
    check({tag, "_addr_r4"}, {59'd0, a4}, {59'd0, ad});
    take(tag);
  endtask

  task automatic run(input string tag, input bp_be_div_op_e o, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input logic early, input logic [4:0] ad);
    launch(o, w, a, b, ad);
    wait_result(tag, early ? 1 : (w ? 33 : 65), early ? 1 : (w ? 17 : 33), exp, ad);
  endtask

  initial begin
    logic [63:0] h1, h4;
    logic        bad, seen;
    int          lat;

    // Reset state
    step();
    check("rst_ready", {62'd0, ready1, ready4}, 64'd3);
    check("rst_v",     {62'd0, v1, v4}, 64'd0);
    check("rst_addr",  {54'd0, addr1, addr4}, 64'd0);
    check("rst_data1", data1, 64'd0);
    check("rst_data4", data4, 64'd0);
    reset = 1'b0;
    step();

    // Full ops and early-outs
    run("div_m7_2",   e_div_op_div,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 5'd1);
    run("rem_m7_2",   e_div_op_rem,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd2);
    run("divu_5_0",   e_div_op_divu, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd3);
    run("div_ovf",    e_div_op_div,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 5'd4);
    run("remu_3_10",  e_div_op_remu, 1'b0, 64'd3, 64'd10, 64'd3, 1'b1, 5'd5);
    run("divw_ovf",   e_div_op_div,  1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1, 5'd6);
    run("remuw_16",   e_div_op_remu, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd16, 64'h0000_0000_0000_000F, 1'b0, 5'd7);
    run("divu_max_3", e_div_op_divu, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 1'b0, 5'd8);
    run("div_100_m7", e_div_op_div,  1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 5'd9);
    run("rem_100_m7", e_div_op_rem,  1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 5'd10);
    run("divw_m100",  e_div_op_div,  1'b1, 64'h1234_5678_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 5'd11);
    run("remw_m100",  e_div_op_rem,  1'b1, 64'h1234_5678_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 5'd12);
    run("divuw_sext", e_div_op_divu, 1'b1, 64'hABCD_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0, 5'd13);
    run("rem_5_0",    e_div_op_rem,  1'b0, 64'd5, 64'd0, 64'd5, 1'b1, 5'd14);
    run("divu_msb",   e_div_op_divu, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 5'd15);
    run("remu_max16", e_div_op_remu, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'd15, 1'b0, 5'd16);
    run("div_3_m10",  e_div_op_div,  1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFF6, 64'd0, 1'b1, 5'd17);
    run("rem_m3_10",  e_div_op_rem,  1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 5'd18);
    run("divuw_5_0",  e_div_op_divu, 1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd19);
    run("divu_shift", e_div_op_divu, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h1000, 64'h0000_1234_5678_9ABC, 1'b0, 5'd20);
    run("remu_shift", e_div_op_remu, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h1000, 64'h0000_0000_0000_0DEF, 1'b0, 5'd21);
    run("divu_1m_3",  e_div_op_divu, 1'b0, 64'd1000000, 64'd3, 64'd333333, 1'b0, 5'd22);
    run("remw_ovf",   e_div_op_rem,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 5'd23);
    run("rem_ovf",    e_div_op_rem,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 5'd24);
    run("remu_near",  e_div_op_remu, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0, 5'd25);
    run("div_nn",     e_div_op_div,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 1'b0, 5'd26);

    // Handshake: yumi held off 5 cycles while a new request waits on v_i
    launch(e_div_op_divu, 1'b0, 64'd100, 64'd7, 5'd27);
    op = e_div_op_remu; rs1 = 64'd100; rs2 = 64'd7; rd_addr = 5'd28; v_i = 1'b1;
    lat = 0; bad = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (ready1 || ready4) bad = 1'b1;
      if (v1) begin lat = c; break; end
      step();
    end
    check("hs_lat", 64'(lat), 64'd65);
    h1 = data1; h4 = data4;
    check("hs_data_r2", h1, 64'd14);
    check("hs_data_r4", h4, 64'd14);
    for (int i = 0; i < 5; i++) begin
      step();
      if (!v1 || !v4 || ready1 || ready4 || data1 !== h1 || data4 !== h4 ||
          addr1 !== 5'd27 || addr4 !== 5'd27) bad = 1'b1;
    end
    check("hs_stable", {63'd0, bad}, 64'd0);
    check("hs_yumi_legal", {62'd0, v1, v4}, 64'd3);
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    check("hs_ready_k1", {62'd0, ready1, ready4}, 64'd3);
    check("hs_v_k1", {62'd0, v1, v4}, 64'd0);
    step();
    v_i = 1'b0;
    check("hs_accepted", {62'd0, ready1, ready4}, 64'd0);
    wait_result("hs_second", 65, 33, 64'd2, 5'd28);

    // Flush in cycle 10 of CALC
    launch(e_div_op_div, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd29);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ready", {62'd0, ready1, ready4}, 64'd3);
    check("flush_v", {62'd0, v1, v4}, 64'd0);
    seen = 1'b0;
    repeat (80) begin
      step();
      if (v1 || v4) seen = 1'b1;
    end
    check("flush_no_v", {63'd0, seen}, 64'd0);

    // Flush with v_i in IDLE must not accept (an early-out would show v_o)
    op = e_div_op_divu; opw = 1'b0; rs1 = 64'd5; rs2 = 64'd0; rd_addr = 5'd30;
    v_i = 1'b1; flush = 1'b1;
    step();
    v_i = 1'b0; flush = 1'b0;
    check("flush_idle_ready", {62'd0, ready1, ready4}, 64'd3);
    check("flush_idle_v", {62'd0, v1, v4}, 64'd0);
    step();
    check("flush_idle_v2", {62'd0, v1, v4}, 64'd0);

    // Asynchronous reset mid-CALC
    launch(e_div_op_div, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd31);
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    check("arst_ready", {62'd0, ready1, ready4}, 64'd3);
    check("arst_v", {62'd0, v1, v4}, 64'd0);
    check("arst_addr", {54'd0, addr1, addr4}, 64'd0);
    check("arst_data1", data1, 64'd0);
    check("arst_data4", data4, 64'd0);
    step();
    reset = 1'b0;
    step();
    check("arst_still_idle", {60'd0, ready1, ready4, v1, v4}, 64'd12);
    run("post_reset", e_div_op_rem, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 5'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
